// File: rtl/m_button_in_pkg.sv
// Shared constants and helpers for the push-button input block.
// Holds the default debounce length, press-counter width and max button count.
// No ports; imported by m_debounce and m_button_in.
package m_button_in_pkg;

    // Default stable time before a level change is accepted (cycles).
    localparam int DEBOUNCE_CYCLES_DEF = 100000;

    // Press counter width; the counter drives a 4-LED display directly.
    localparam int CNT_W = 4;

    // Largest supported number of buttons.
    localparam int NBTN_MAX = 8;

    // Number of set bits in a button vector. NBTN_MAX = 8 gives at most 8,
    // which still fits in CNT_W bits.
    function automatic logic [CNT_W-1:0] popcount(input logic [NBTN_MAX-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NBTN_MAX; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/m_button_in_debounce.sv
// One-bit synchronizer + debouncer: 2-flop sync, then a level flop that follows
// the synced input only after it has differed for DEBOUNCE_CYCLES samples.
// Latency: level changes on edge DEBOUNCE_CYCLES+2 after a stable raw change; no backpressure.
// Ports: clk, rst_n (async, active-low), btn (raw async level), level (debounced level).
module m_debounce
    import m_button_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Metastability guard: nothing downstream looks at btn or sync1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // The counter measures how long the synced input has disagreed with the
    // accepted level. Any agreeing sample restarts the measurement, so a
    // glitch shorter than DEBOUNCE_CYCLES samples never reaches the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/m_button_in.sv
// Push-button front end: per-button debounce, press/release pulses, press counter.
// Latency: level at edge DEBOUNCE_CYCLES+2, pulse one cycle later, count one more; no backpressure.
// Optional macro BTN_RELEASE_EVT_EN enables release pulses; otherwise w_released is tied to 0.
// Ports: w_clk, w_rst_n (async, active-low), w_btn[NBTN] raw levels, w_clr (sync counter clear),
//        w_level[NBTN] debounced, w_pressed/w_released[NBTN] 1-cycle pulses, w_cnt[4] presses mod 16.
module m_button_in
    import m_button_in_pkg::*;
#(
    parameter int NBTN            = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic [NBTN-1:0]  w_btn,
    input  logic             w_clr,
    output logic [NBTN-1:0]  w_level,
    output logic [NBTN-1:0]  w_pressed,
    output logic [NBTN-1:0]  w_released,
    output logic [CNT_W-1:0] w_cnt
);

    // Debounced level one cycle earlier, for edge detection.
    logic [NBTN-1:0] level_d;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        m_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (w_clk),
            .rst_n (w_rst_n),
            .btn   (w_btn[i]),
            .level (w_level[i])
        );
    end

    // Pulses are registered: high in the cycle after the level changed.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            level_d   <= '0;
            w_pressed <= '0;
        end else begin
            level_d   <= w_level;
            w_pressed <= w_level & ~level_d;
        end
    end

`ifdef BTN_RELEASE_EVT_EN
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_released <= '0;
        end else begin
            w_released <= ~w_level & level_d;
        end
    end
`else
    assign w_released = '0;
`endif

    // Clear has priority: presses pulsing in the clear cycle are not counted.
    // The sum truncates to CNT_W bits, giving the modulo-16 wrap.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_cnt <= '0;
        end else if (w_clr) begin
            w_cnt <= '0;
        end else begin
            w_cnt <= w_cnt + popcount(NBTN_MAX'(w_pressed));
        end
    end

endmodule

// File: tb/tb_m_button_in.sv
// Self-checking bench for m_button_in with NBTN=4, DEBOUNCE_CYCLES=4.
// Reference model: a button's accepted level flips once the last D synchronized
// samples (raw samples delayed two edges) all disagree with it.
module tb_m_button_in;

    localparam int NBTN = 4;
    localparam int D    = 4;
`ifdef BTN_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic            w_clk = 1'b0;
    logic            w_rst_n;
    logic [NBTN-1:0] w_btn;
    logic            w_clr;
    logic [NBTN-1:0] w_level;
    logic [NBTN-1:0] w_pressed;
    logic [NBTN-1:0] w_released;
    logic [3:0]      w_cnt;

    int errors = 0;
    int checks = 0;

    m_button_in #(
        .NBTN            (NBTN),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_btn      (w_btn),
        .w_clr      (w_clr),
        .w_level    (w_level),
        .w_pressed  (w_pressed),
        .w_released (w_released),
        .w_cnt      (w_cnt)
    );

    always #5 w_clk = ~w_clk;

    // ---------------- reference model ----------------
    logic [NBTN-1:0] hist [0:D+1];   // hist[0] = raw value sampled at latest edge
    logic [NBTN-1:0] exp_level, exp_level_d, exp_pressed, exp_released;
    logic [3:0]      exp_cnt;

    always @(posedge w_clk or negedge w_rst_n) begin
        logic [NBTN-1:0] nl;
        bit              all_diff;
        if (!w_rst_n) begin
            for (int k = 0; k <= D + 1; k++) hist[k] = '0;
            exp_level    = '0;
            exp_level_d  = '0;
            exp_pressed  = '0;
            exp_released = '0;
            exp_cnt      = '0;
        end else begin
            exp_cnt      = w_clr ? 4'd0 : exp_cnt + 4'($countones(exp_pressed));
            exp_pressed  = exp_level & ~exp_level_d;
            exp_released = REL_EN ? (~exp_level & exp_level_d) : '0;
            exp_level_d  = exp_level;
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = w_btn;
            nl = exp_level;
            for (int i = 0; i < NBTN; i++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++) begin
                    if (hist[k][i] == exp_level[i]) all_diff = 1'b0;
                end
                if (all_diff) nl[i] = ~exp_level[i];
            end
            exp_level = nl;
        end
    end

    task automatic tick();
        @(posedge w_clk);
        @(negedge w_clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge w_clk);
        #1;
        checks++;
        if ({w_level, w_pressed, w_released, w_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state got lvl=%b prs=%b rel=%b cnt=%0d required all 0",
                     w_level, w_pressed, w_released, w_cnt);
        end
        @(negedge w_clk);
        w_rst_n = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({w_level, w_pressed, w_released, w_cnt} !== {exp_level, exp_pressed, exp_released, exp_cnt}) begin
                errors++;
                $display("FAIL reset_idle got lvl=%b prs=%b cnt=%0d required lvl=%b prs=%b cnt=%0d",
                         w_level, w_pressed, w_cnt, exp_level, exp_pressed, exp_cnt);
            end
        end
    endtask

    task automatic test_single_press();
        w_btn[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if ({w_level, w_pressed, w_released, w_cnt} !== {exp_level, exp_pressed, exp_released, exp_cnt}) begin
                errors++;
                $display("FAIL single_model edge=%0d got lvl=%b prs=%b cnt=%0d required lvl=%b prs=%b cnt=%0d",
                         e, w_level, w_pressed, w_cnt, exp_level, exp_pressed, exp_cnt);
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (w_level[0] !== (e == 6)) begin
                    errors++;
                    $display("FAIL single_level_edge%0d got %b required %b", e, w_level[0], e == 6);
                end
            end
            if (e == 7 || e == 8) begin
                checks++;
                if (w_pressed !== ((e == 7) ? 4'b0001 : 4'b0000)) begin
                    errors++;
                    $display("FAIL single_pulse_edge%0d got %b required %b", e, w_pressed,
                             (e == 7) ? 4'b0001 : 4'b0000);
                end
            end
        end
        checks++;
        if (w_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_cnt got %0d required 1", w_cnt);
        end
        w_btn[0] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_glitch();
        bit seen;
        seen = 1'b0;
        w_btn[1] = 1'b1;
        repeat (3) tick();
        w_btn[1] = 1'b0;
        repeat (10) begin
            tick();
            if (w_pressed != 0 || w_level != 0) seen = 1'b1;
            checks++;
            if ({w_level, w_pressed, w_released, w_cnt} !== {exp_level, exp_pressed, exp_released, exp_cnt}) begin
                errors++;
                $display("FAIL glitch_model got lvl=%b prs=%b cnt=%0d required lvl=%b prs=%b cnt=%0d",
                         w_level, w_pressed, w_cnt, exp_level, exp_pressed, exp_cnt);
            end
        end
        checks++;
        if (seen || w_cnt !== 4'd1) begin
            errors++;
            $display("FAIL glitch_ignored got activity=%b cnt=%0d required activity=0 cnt=1", seen, w_cnt);
        end
    endtask

    task automatic test_all_buttons();
        bit seen;
        w_clr = 1'b1;
        tick();
        w_clr = 1'b0;
        checks++;
        if (w_cnt !== 4'd0) begin
            errors++;
            $display("FAIL all_clear got %0d required 0", w_cnt);
        end
        for (int r = 0; r < 4; r++) begin
            seen = 1'b0;
            w_btn = 4'b1111;
            repeat (8) begin
                tick();
                if (w_pressed === 4'b1111) seen = 1'b1;
                checks++;
                if ({w_level, w_pressed, w_released, w_cnt} !== {exp_level, exp_pressed, exp_released, exp_cnt}) begin
                    errors++;
                    $display("FAIL all_model r=%0d got lvl=%b prs=%b cnt=%0d required lvl=%b prs=%b cnt=%0d",
                             r, w_level, w_pressed, w_cnt, exp_level, exp_pressed, exp_cnt);
                end
            end
            checks++;
            if (!seen || w_cnt !== 4'((r + 1) * 4)) begin
                errors++;
                $display("FAIL all_pulse r=%0d got together=%b cnt=%0d required together=1 cnt=%0d",
                         r, seen, w_cnt, 4'((r + 1) * 4));
            end
            w_btn = 4'b0000;
            repeat (8) tick();
        end
        checks++;
        if (w_cnt !== 4'd0) begin
            errors++;
            $display("FAIL all_wrap got %0d required 0", w_cnt);
        end
    endtask

    task automatic test_wrap_clr();
        bit found;
        for (int p = 1; p <= 17; p++) begin
            w_btn[3] = 1'b1;
            repeat (8) tick();
            w_btn[3] = 1'b0;
            repeat (8) tick();
            if (p == 15 || p == 16 || p == 17) begin
                checks++;
                if (w_cnt !== 4'(p)) begin
                    errors++;
                    $display("FAIL wrap_cnt press=%0d got %0d required %0d", p, w_cnt, 4'(p));
                end
            end
        end
        found = 1'b0;
        w_btn[0] = 1'b1;
        for (int e = 0; e < 12 && !found; e++) begin
            tick();
            if (w_pressed[0] === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL clr_press_timeout got no pulse required pulse within 12 cycles");
        end else begin
            w_clr = 1'b1;
            tick();
            w_clr = 1'b0;
            checks++;
            if (w_cnt !== 4'd0) begin
                errors++;
                $display("FAIL clr_wins got %0d required 0", w_cnt);
            end
        end
        w_btn[0] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        w_btn = 4'b0010;
        repeat (10) tick();
        w_btn = 4'b0110;
        repeat (4) tick();              // button 2 debounce counter now at 2
        w_rst_n = 1'b0;
        #1;
        checks++;
        if ({w_level, w_pressed, w_released, w_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_async got lvl=%b prs=%b rel=%b cnt=%0d required all 0",
                     w_level, w_pressed, w_released, w_cnt);
        end
        repeat (2) @(negedge w_clk);
        w_rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({w_level, w_pressed, w_released, w_cnt} !== {exp_level, exp_pressed, exp_released, exp_cnt}) begin
                errors++;
                $display("FAIL rst_model edge=%0d got lvl=%b prs=%b cnt=%0d required lvl=%b prs=%b cnt=%0d",
                         e, w_level, w_pressed, w_cnt, exp_level, exp_pressed, exp_cnt);
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (w_level[2] !== (e == 6)) begin
                    errors++;
                    $display("FAIL rst_level2_edge%0d got %b required %b", e, w_level[2], e == 6);
                end
            end
        end
        w_btn = 4'b0000;
        repeat (10) tick();
    endtask

    task automatic test_release();
        int pulses;
        pulses = 0;
        w_btn[0] = 1'b1;
        repeat (10) tick();
        w_btn[0] = 1'b0;
        repeat (12) begin
            tick();
            if (w_released[0] === 1'b1) pulses++;
            checks++;
            if (w_released !== exp_released || w_level !== exp_level) begin
                errors++;
                $display("FAIL release_model got lvl=%b rel=%b required lvl=%b rel=%b",
                         w_level, w_released, exp_level, exp_released);
            end
        end
        checks++;
        if (pulses != (REL_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL release_pulses got %0d required %0d", pulses, REL_EN ? 1 : 0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NBTN; i++) begin
                if ($urandom_range(0, 6) == 0) w_btn[i] = ~w_btn[i];
            end
            w_clr = ($urandom_range(0, 39) == 0);
            tick();
            checks++;
            if ({w_level, w_pressed, w_released, w_cnt} !== {exp_level, exp_pressed, exp_released, exp_cnt}) begin
                errors++;
                $display("FAIL random c=%0d got lvl=%b prs=%b rel=%b cnt=%0d required lvl=%b prs=%b rel=%b cnt=%0d",
                         c, w_level, w_pressed, w_released, w_cnt,
                         exp_level, exp_pressed, exp_released, exp_cnt);
            end
        end
        w_clr = 1'b0;
    endtask

    initial begin
        w_btn   = '0;
        w_clr   = 1'b0;
        w_rst_n = 1'b1;
        #1 w_rst_n = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_all_buttons();
        test_wrap_clr();
        test_reset_mid();
        test_release();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_button_in.md
M_BUTTON_IN -- requirements
Module: m_button_in

Interface
REQ-001 SHALL have parameter NBTN, default 4, meaning number of push-button inputs (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning stable cycles required before accepting a change (min 2).
REQ-003 SHALL have port w_clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port w_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port w_btn  input  NBTN  raw asynchronous button levels, 1 = pressed.
REQ-006 SHALL have port w_clr  input  1  synchronous clear of press counter.
REQ-007 SHALL have port w_level  output  NBTN  debounced button levels.
REQ-008 SHALL have port w_pressed  output  NBTN  one-cycle pulse per debounced 0->1 transition.
REQ-009 SHALL have port w_released  output  NBTN  one-cycle pulse per debounced 1->0 transition (see Configuration).
REQ-010 SHALL have port w_cnt  output  4  total accepted presses, modulo 16, LED-ready.

Function
REQ-011 SHALL pass each w_btn bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep per bit a debounce counter of width clog2(DEBOUNCE_CYCLES); counter clears on any cycle where synchronized input equals w_level.
REQ-013 SHALL increment the counter each cycle synchronized input differs from w_level; when it differs with counter == DEBOUNCE_CYCLES-1, SHALL toggle w_level and clear the counter.
REQ-014 SHALL update w_level on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples a stable new raw value; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave w_level unchanged.
REQ-015 SHALL assert w_pressed[i] (resp. w_released[i]) registered, high exactly in the cycle after w_level[i] rises (resp. falls), for one cycle only.
REQ-016 SHALL increment w_cnt by popcount(w_pressed) each cycle, wrapping modulo 16 (15+1 = 0; 15+2 = 1).
REQ-017 SHALL, when w_clr is high, set w_cnt to 0 on the next edge; w_clr SHALL win over a simultaneous press (presses in that cycle are dropped).
REQ-018 SHALL treat buttons independently; simultaneous transitions on several bits SHALL each debounce and pulse in the same cycle.

Reset
REQ-019 SHALL, while w_rst_n is low, force synchronizers, debounce counters, w_level, w_pressed, w_released and w_cnt to 0 immediately.
REQ-020 SHALL, on reset release with a button held, treat it as a new press: w_level rises after the REQ-014 latency and w_pressed pulses.
REQ-021 SHALL discard any partial debounce count on reset mid-operation.

Configuration
REQ-022 SHALL, with macro BTN_RELEASE_EVT_EN defined, generate w_released per REQ-015.
REQ-023 SHALL, without BTN_RELEASE_EVT_EN, keep port w_released present and tie it to constant 0, with no release-detect flops synthesized.

Structure
REQ-024 SHALL place the default DEBOUNCE_CYCLES, the w_cnt width constant (4) and the maximum NBTN in a shared package.
REQ-025 SHALL implement one bit of synchronizer plus debounce counter plus level flop as sub-module m_debounce, instantiated NBTN times by generate.

Verification (DEBOUNCE_CYCLES=4, NBTN=4)
REQ-026 SHALL cover: w_btn[0] 0->1 held 10 cycles -> w_level[0] rises on 6th edge, w_pressed[0] high 1 cycle, w_cnt 0->1.
REQ-027 SHALL cover: w_btn[1] high for 3 cycles then low -> w_level, w_pressed, w_cnt unchanged.
REQ-028 SHALL cover: w_btn = 4'b1111 together, stable -> all four w_pressed pulse in the same cycle, w_cnt 0->4; repeat 4 times -> w_cnt wraps to 0.
REQ-029 SHALL cover: w_cnt = 15 with one press -> w_cnt = 0; w_clr coincident with a press pulse -> w_cnt = 0.
REQ-030 SHALL cover: w_rst_n low for 2 cycles while w_btn[2] held and its counter at 2 -> all outputs 0 asynchronously; after release w_level[2] rises 6 edges later.
REQ-031 SHALL cover: release of w_btn[0] -> w_released[0] pulses 1 cycle with BTN_RELEASE_EVT_EN, stays 0 without it.
